// File: rtl/lsu_access_ctrl_if.sv
// L1 data-cache request/ready port between the LSU and the cache.
// master drives the request side, slave answers with ready/rdata.
interface lsu_access_ctrl_if #(
  parameter int ADDR_W = 32
) ();
  logic              dc_req;
  logic              dc_we;
  logic [ADDR_W-1:0] dc_addr;
  logic [3:0]        dc_byte_en;
  logic [31:0]       dc_wdata;
  logic              dc_ready;
  logic [31:0]       dc_rdata;

  modport master (
    output dc_req,
    output dc_we,
    output dc_addr,
    output dc_byte_en,
    output dc_wdata,
    input  dc_ready,
    input  dc_rdata
  );

  modport slave (
    input  dc_req,
    input  dc_we,
    input  dc_addr,
    input  dc_byte_en,
    input  dc_wdata,
    output dc_ready,
    output dc_rdata
  );
endinterface

// File: rtl/lsu_access_ctrl.sv
// MEM-stage load/store sequencer onto the L1 D-cache port.
// Splits misaligned accesses into two word beats and extends load data.
module lsu_access_ctrl #(
  parameter int ALLOW_MISALIGNED = 1,
  parameter int ADDR_W           = 32
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_stall,
  output logic              o_done,
  output logic [31:0]       o_load_data,
  output logic              o_misalign_exc,
  lsu_access_ctrl_if.master io_dc
);

  localparam bit LP_SPLIT_OK = (ALLOW_MISALIGNED != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BEAT0,
    S_BEAT1,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [2:0]        r_f3;
  logic [1:0]        r_off;
  logic              r_split;
  logic              r_we;
  logic [3:0]        r_be_hi;
  logic [31:0]       r_wd_hi;
  logic [31:0]       r_lo;
  logic              r_req;
  logic              r_dc_we;
  logic [ADDR_W-1:0] r_dc_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_dc_wdata;
  logic              r_done;
  logic              r_exc;
  logic [31:0]       r_load;

  logic              w_start;
  logic              w_we;
  logic [1:0]        w_off;
  logic              w_is_b;
  logic              w_is_h;
  logic              w_is_w;
  logic [3:0]        w_mask;
  logic              w_split;
  logic [7:0]        w_be8;
  logic [63:0]       w_wd64;
  logic [ADDR_W-1:0] w_waddr;
  logic              w_in_b1;
  logic [31:0]       w_hi;
  logic [31:0]       w_lo;
  logic [31:0]       w_r;
  logic [31:0]       w_ext;

  assign w_start = i_mem_read | i_mem_write;
  assign w_we    = i_mem_write & ~i_mem_read;
  assign w_off   = i_addr[1:0];
  assign w_is_b  = (i_funct3[1:0] == 2'b00);
  assign w_is_h  = (i_funct3[1:0] == 2'b01);
  assign w_is_w  = ~w_is_b & ~w_is_h;

  always_comb begin
    w_mask = 4'b1111;
    unique case (1'b1)
      w_is_b:  w_mask = 4'b0001;
      w_is_h:  w_mask = 4'b0011;
      default: w_mask = 4'b1111;
    endcase
  end

  assign w_split = (w_is_h & (w_off == 2'd3))
                 | (w_is_w & (w_off != 2'd0));

  // Upper halves of the shifted lanes are the second-beat values
  assign w_be8   = {4'b0000, w_mask} << w_off;
  assign w_wd64  = {32'h0, i_wdata} << {w_off, 3'b000};
  assign w_waddr = {i_addr[ADDR_W-1:2], 2'b00};

  assign w_in_b1 = (r_state == S_BEAT1);
  assign w_hi    = w_in_b1 ? io_dc.dc_rdata : 32'h0;
  assign w_lo    = w_in_b1 ? r_lo : io_dc.dc_rdata;
  assign w_r     = 32'({w_hi, w_lo} >> {r_off, 3'b000});

  always_comb begin
    w_ext = w_r;
    case (r_f3)
      3'b000:  w_ext = {{24{w_r[7]}}, w_r[7:0]};
      3'b100:  w_ext = {24'h0, w_r[7:0]};
      3'b001:  w_ext = {{16{w_r[15]}}, w_r[15:0]};
      3'b101:  w_ext = {16'h0, w_r[15:0]};
      default: w_ext = w_r;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state    <= S_IDLE;
      r_f3       <= '0;
      r_off      <= '0;
      r_split    <= 1'b0;
      r_we       <= 1'b0;
      r_be_hi    <= '0;
      r_wd_hi    <= '0;
      r_lo       <= '0;
      r_req      <= 1'b0;
      r_dc_we    <= 1'b0;
      r_dc_addr  <= '0;
      r_be       <= '0;
      r_dc_wdata <= '0;
      r_done     <= 1'b0;
      r_exc      <= 1'b0;
      r_load     <= '0;
    end else begin
      r_done <= 1'b0;
      r_exc  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_f3    <= i_funct3;
            r_off   <= w_off;
            r_split <= w_split;
            r_we    <= w_we;
            r_be_hi <= w_be8[7:4];
            r_wd_hi <= w_wd64[63:32];
            if (w_split && !LP_SPLIT_OK) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_exc   <= 1'b1;
            end else begin
              r_state    <= S_BEAT0;
              r_req      <= 1'b1;
              r_dc_we    <= w_we;
              r_dc_addr  <= w_waddr;
              r_be       <= w_be8[3:0];
              r_dc_wdata <= w_wd64[31:0];
            end
          end
        end
        S_BEAT0: begin
          if (io_dc.dc_ready) begin
            r_lo <= io_dc.dc_rdata;
            if (r_split) begin
              r_state    <= S_BEAT1;
              r_dc_addr  <= r_dc_addr + ADDR_W'(4);
              r_be       <= r_be_hi;
              r_dc_wdata <= r_wd_hi;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_req   <= 1'b0;
              r_dc_we <= 1'b0;
              if (!r_we) r_load <= w_ext;
            end
          end
        end
        S_BEAT1: begin
          if (io_dc.dc_ready) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_req   <= 1'b0;
            r_dc_we <= 1'b0;
            if (!r_we) r_load <= w_ext;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Same instruction is still in MEM during DONE, so no stall there
  assign o_stall = i_reset & (((r_state == S_IDLE) & w_start)
                 | (r_state == S_BEAT0)
                 | (r_state == S_BEAT1));

  assign o_done           = r_done;
  assign o_misalign_exc   = r_exc;
  assign o_load_data      = r_load;
  assign io_dc.dc_req     = r_req;
  assign io_dc.dc_we      = r_dc_we;
  assign io_dc.dc_addr    = r_dc_addr;
  assign io_dc.dc_byte_en = r_be;
  assign io_dc.dc_wdata   = r_dc_wdata;

endmodule
